// File: rtl/alu_op_issuer_pkg.sv
// Shared encodings for the ALU op issuer: ALU_control codes, R-type funct
// codes, ALUOp codes and the issuer FSM state type.
package alu_op_issuer_pkg;

  // ALU_control codes understood by the registered 32-bit ALU
  localparam logic [3:0] CTL_AND = 4'b0000;
  localparam logic [3:0] CTL_OR  = 4'b0001;
  localparam logic [3:0] CTL_ADD = 4'b0010;
  localparam logic [3:0] CTL_SUB = 4'b0110;
  localparam logic [3:0] CTL_SLT = 4'b0111;
  localparam logic [3:0] CTL_NOR = 4'b1100;

  // R-type funct field values
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_NOR = 6'b100111;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  // ALUOp values from the main decoder
  localparam logic [1:0] ALUOP_MEM   = 2'b00;
  localparam logic [1:0] ALUOP_BEQ   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_RSVD  = 2'b11;

  // Issuer FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

endpackage

// File: rtl/alu_op_issuer_if.sv
// Upstream op handshake and downstream result handshake of the ALU op issuer.
// master = producer of ops / consumer of results, slave = the issuer.
interface alu_op_issuer_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_aluop;
  logic [5:0]        in_funct;
  logic [DATA_W-1:0] in_src1;
  logic [DATA_W-1:0] in_src2;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic              out_zero;
  logic              out_cout;
  logic              out_overflow;
  logic              out_illegal;

  modport master (
    output in_valid, in_aluop, in_funct, in_src1, in_src2, out_ready,
    input  in_ready, out_valid, out_result, out_zero, out_cout, out_overflow, out_illegal
  );

  modport slave (
    input  in_valid, in_aluop, in_funct, in_src1, in_src2, out_ready,
    output in_ready, out_valid, out_result, out_zero, out_cout, out_overflow, out_illegal
  );
endinterface

// File: rtl/alu_op_issuer_ctrl_dec.sv
// Combinational ALU control decoder: (ALUOp, funct) -> ALU_control code,
// plus an illegal flag for reserved ALUOp or unknown R-type funct.
module alu_ctrl_dec
  import alu_op_issuer_pkg::*;
(
  input  logic [1:0] i_aluop,
  input  logic [5:0] i_funct,
  output logic [3:0] o_ctl,
  output logic       o_illegal
);

  // Map the instruction class (and funct for R-type) onto an ALU operation
  always_comb begin
    o_ctl     = CTL_AND;
    o_illegal = 1'b0;
    case (i_aluop)
      ALUOP_MEM: o_ctl = CTL_ADD;
      ALUOP_BEQ: o_ctl = CTL_SUB;
      ALUOP_RTYPE: begin
        case (i_funct)
          FUNCT_ADD: o_ctl = CTL_ADD;
          FUNCT_SUB: o_ctl = CTL_SUB;
          FUNCT_AND: o_ctl = CTL_AND;
          FUNCT_OR:  o_ctl = CTL_OR;
          FUNCT_NOR: o_ctl = CTL_NOR;
          FUNCT_SLT: o_ctl = CTL_SLT;
          default:   o_illegal = 1'b1;
        endcase
      end
      ALUOP_RSVD: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_op_issuer.sv
// ALU op issuer: accepts decoded ops, drives the registered ALU, captures its
// result one cycle after issue and holds it until the downstream takes it.
module alu_op_issuer
  import alu_op_issuer_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  alu_op_issuer_if.slave    bus,
  output logic [3:0]        alu_control,
  output logic [DATA_W-1:0] alu_src1,
  output logic [DATA_W-1:0] alu_src2,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  input  logic              alu_cout,
  input  logic              alu_overflow,
  output logic [CNT_W-1:0]  op_count
);

  state_t            r_state;
  logic [3:0]        r_ctl;
  logic [DATA_W-1:0] r_src1;
  logic [DATA_W-1:0] r_src2;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_result;
  logic              r_out_zero;
  logic              r_out_cout;
  logic              r_out_overflow;
  logic              r_out_illegal;
  logic [CNT_W-1:0]  r_op_count;

  logic [3:0]        w_dec_ctl;
  logic              w_dec_illegal;
  logic              w_in_ready;
  logic              w_accept;
  logic              w_out_hs;

  alu_ctrl_dec u_dec (
    .i_aluop   (bus.in_aluop),
    .i_funct   (bus.in_funct),
    .o_ctl     (w_dec_ctl),
    .o_illegal (w_dec_illegal)
  );

  // Ready in IDLE, or in HOLD when the held result leaves this same cycle.
  // Gated by rst so the port reads 0 for the whole reset pulse.
  assign w_in_ready = ~rst & ((r_state == ST_IDLE) |
                              ((r_state == ST_HOLD) & bus.out_ready));
  assign w_accept   = bus.in_valid & w_in_ready;
  assign w_out_hs   = r_out_valid & bus.out_ready;

  assign bus.in_ready     = w_in_ready;
  assign bus.out_valid    = r_out_valid;
  assign bus.out_result   = r_out_result;
  assign bus.out_zero     = r_out_zero;
  assign bus.out_cout     = r_out_cout;
  assign bus.out_overflow = r_out_overflow;
  assign bus.out_illegal  = r_out_illegal;
  assign alu_control      = r_ctl;
  assign alu_src1         = r_src1;
  assign alu_src2         = r_src2;
  assign op_count         = r_op_count;

  // Issue FSM with op registers and result capture registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_ctl          <= 4'b0000;
      r_src1         <= '0;
      r_src2         <= '0;
      r_out_valid    <= 1'b0;
      r_out_result   <= '0;
      r_out_zero     <= 1'b0;
      r_out_cout     <= 1'b0;
      r_out_overflow <= 1'b0;
      r_out_illegal  <= 1'b0;
    end else if (w_accept) begin
      // Same handling whether accepted from IDLE or back-to-back from HOLD
      if (w_dec_illegal) begin
        // Illegal op bypasses the ALU; op registers keep the last legal op
        r_out_valid    <= 1'b1;
        r_out_result   <= '0;
        r_out_zero     <= 1'b0;
        r_out_cout     <= 1'b0;
        r_out_overflow <= 1'b0;
        r_out_illegal  <= 1'b1;
        r_state        <= ST_HOLD;
      end else begin
        r_ctl       <= w_dec_ctl;
        r_src1      <= bus.in_src1;
        r_src2      <= bus.in_src2;
        r_out_valid <= 1'b0;
        r_state     <= ST_ISSUE;
      end
    end else begin
      case (r_state)
        ST_ISSUE: r_state <= ST_WAIT;
        ST_WAIT: begin
          r_out_valid    <= 1'b1;
          r_out_result   <= alu_result;
          r_out_zero     <= alu_zero;
          r_out_cout     <= alu_cout;
          r_out_overflow <= alu_overflow;
          r_out_illegal  <= 1'b0;
          r_state        <= ST_HOLD;
        end
        ST_HOLD: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Saturating count of legal results taken by the downstream
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op_count <= '0;
    end else if (w_out_hs && !r_out_illegal && (r_op_count != {CNT_W{1'b1}})) begin
      r_op_count <= r_op_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_op_issuer.sv
// Randomized scoreboard bench for alu_op_issuer with a behavioural ALU model.
module tb_alu_op_issuer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_op_issuer_if #(.DATA_W(32)) bus ();

  logic [3:0]  alu_control;
  logic [31:0] alu_src1, alu_src2, alu_result;
  logic        alu_zero, alu_cout, alu_overflow;
  logic [15:0] op_count;

  alu_op_issuer #(.DATA_W(32), .CNT_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus.slave),
    .alu_control  (alu_control),
    .alu_src1     (alu_src1),
    .alu_src2     (alu_src2),
    .alu_result   (alu_result),
    .alu_zero     (alu_zero),
    .alu_cout     (alu_cout),
    .alu_overflow (alu_overflow),
    .op_count     (op_count)
  );

  typedef enum logic [2:0] {K_ADD, K_SUB, K_AND, K_OR, K_NOR, K_SLT, K_ILL} kind_e;
  typedef struct packed {
    logic [31:0] res;
    logic        z;
    logic        c;
    logic        v;
    logic        ill;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          exp_cnt = 0;
  int          n_txn = 0;
  logic [3:0]  last_ctl = 4'b0000;
  bit          rand_ready_en = 1'b0;

  // Operation semantics in plain arithmetic
  function automatic exp_t arith(kind_e k, logic [31:0] a, logic [31:0] b);
    exp_t e;
    logic [32:0] s;
    e = '0;
    s = '0;
    case (k)
      K_ADD: begin
        s = {1'b0, a} + {1'b0, b};
        e.res = s[31:0];
        e.c = s[32];
        e.v = (a[31] == b[31]) && (s[31] != a[31]);
      end
      K_SUB: begin
        e.res = a - b;
        e.c = (a >= b);
        e.v = (a[31] != b[31]) && (e.res[31] != a[31]);
      end
      K_AND: e.res = a & b;
      K_OR:  e.res = a | b;
      K_NOR: e.res = ~(a | b);
      K_SLT: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: e.ill = 1'b1;
    endcase
    e.z = (k != K_ILL) && (e.res == 32'd0);
    return e;
  endfunction

  function automatic kind_e instr_kind(logic [1:0] op, logic [5:0] f);
    if (op == 2'b00) return K_ADD;
    if (op == 2'b01) return K_SUB;
    if (op == 2'b11) return K_ILL;
    case (f)
      6'h20:   return K_ADD;
      6'h22:   return K_SUB;
      6'h24:   return K_AND;
      6'h25:   return K_OR;
      6'h27:   return K_NOR;
      6'h2A:   return K_SLT;
      default: return K_ILL;
    endcase
  endfunction

  function automatic logic [3:0] kind_ctl(kind_e k);
    case (k)
      K_ADD:   return 4'b0010;
      K_SUB:   return 4'b0110;
      K_AND:   return 4'b0000;
      K_OR:    return 4'b0001;
      K_NOR:   return 4'b1100;
      K_SLT:   return 4'b0111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic kind_e ctl_kind(logic [3:0] c);
    case (c)
      4'b0010: return K_ADD;
      4'b0110: return K_SUB;
      4'b0000: return K_AND;
      4'b0001: return K_OR;
      4'b1100: return K_NOR;
      4'b0111: return K_SLT;
      default: return K_ILL;
    endcase
  endfunction

  // Registered ALU: one cycle from operands to result, cleared while rst is high
  exp_t alu_q;
  always @(posedge clk or posedge rst) begin
    if (rst) alu_q <= '0;
    else     alu_q <= arith(ctl_kind(alu_control), alu_src1, alu_src2);
  end
  assign alu_result   = alu_q.res;
  assign alu_zero     = alu_q.z;
  assign alu_cout     = alu_q.c;
  assign alu_overflow = alu_q.v;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: compare every delivered result against the scoreboard head
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_cnt = 0;
      end else if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got result 0x%08h with empty scoreboard", bus.out_result);
        end else begin
          e = sb.pop_front();
          n_txn++;
          $display("txn %0d result=0x%08h z=%0d c=%0d v=%0d ill=%0d cnt=%0d",
                   n_txn, bus.out_result, bus.out_zero, bus.out_cout,
                   bus.out_overflow, bus.out_illegal, op_count);
          check("out_result", bus.out_result, e.res);
          check("out_zero", bus.out_zero, e.z);
          check("out_cout", bus.out_cout, e.c);
          check("out_overflow", bus.out_overflow, e.v);
          check("out_illegal", bus.out_illegal, e.ill);
          check("op_count", op_count, exp_cnt);
          if (!e.ill) exp_cnt++;
        end
      end
    end
  end

  // Random downstream back-pressure
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready_en) bus.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic present(input logic [1:0] op, input logic [5:0] f,
                         input logic [31:0] a, input logic [31:0] b);
    bus.in_valid = 1'b1;
    bus.in_aluop = op;
    bus.in_funct = f;
    bus.in_src1  = a;
    bus.in_src2  = b;
  endtask

  // Wait (bounded) for the accept edge, record the expectation, drop valid
  task automatic finish_accept(input logic [1:0] op, input logic [5:0] f,
                               input logic [31:0] a, input logic [31:0] b);
    bit ok;
    kind_e k;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1'b1;
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: got in_ready=0 for 300 cycles expected 1");
    end else begin
      k = instr_kind(op, f);
      sb.push_back(arith(k, a, b));
      if (k != K_ILL) last_ctl = kind_ctl(k);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_op(input logic [1:0] op, input logic [5:0] f,
                         input logic [31:0] a, input logic [31:0] b);
    @(posedge clk);
    #1;
    present(op, f, a, b);
    finish_accept(op, f, a, b);
  endtask

  // Let every outstanding result drain with out_ready held high, end in IDLE
  task automatic wait_drain();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 500 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  // One op from IDLE: check issued control/operands and result latency
  task automatic directed(input string tag, input logic [1:0] op, input logic [5:0] f,
                          input logic [31:0] a, input logic [31:0] b);
    kind_e k;
    logic [3:0] prev_ctl;
    int lat;
    wait_drain();
    k = instr_kind(op, f);
    prev_ctl = last_ctl;
    send_op(op, f, a, b);
    if (k == K_ILL) begin
      check({tag, "_ctl_held"}, alu_control, prev_ctl);
    end else begin
      check({tag, "_ctl"}, alu_control, kind_ctl(k));
      check({tag, "_src1"}, alu_src1, a);
      check({tag, "_src2"}, alu_src2, b);
    end
    lat = 1;
    while (!bus.out_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_latency"}, lat, (k == K_ILL) ? 1 : 3);
  endtask

  initial begin
    logic [1:0]  op;
    logic [5:0]  f;
    logic [31:0] a, b;
    logic [5:0]  legal_f [6];
    logic [31:0] edge_v [5];
    legal_f = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
    edge_v  = '{32'h0000_0000, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0001};

    bus.in_valid  = 1'b0;
    bus.in_aluop  = 2'b00;
    bus.in_funct  = 6'h00;
    bus.in_src1   = '0;
    bus.in_src2   = '0;
    bus.out_ready = 1'b0;

    // Reset state
    #2;
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_alu_control", alu_control, 0);
    check("rst_op_count", op_count, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("idle_in_ready", bus.in_ready, 1);

    // Directed cases
    directed("add_5_7", 2'b10, 6'h20, 32'd5, 32'd7);
    directed("beq_eq", 2'b01, 6'h00, 32'h0000_1234, 32'h0000_1234);
    directed("add_ovf", 2'b10, 6'h20, 32'h7FFF_FFFF, 32'h0000_0001);
    directed("illegal_funct", 2'b10, 6'h00, 32'h1111_1111, 32'h2222_2222);
    directed("illegal_aluop", 2'b11, 6'h20, 32'h3, 32'h4);
    directed("slt_neg", 2'b10, 6'h2A, 32'hFFFF_FFFF, 32'h0000_0001);
    directed("nor", 2'b10, 6'h27, 32'h0F0F_0000, 32'h0000_00F0);
    directed("sw_add", 2'b00, 6'h3F, 32'hFFFF_FFFF, 32'h0000_0001);

    // Hold result under back-pressure, then back-to-back accept
    wait_drain();
    bus.out_ready = 1'b0;
    send_op(2'b10, 6'h20, 32'd1, 32'd1);
    for (int i = 0; i < 10 && !bus.out_valid; i++) begin
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("hold_out_valid", bus.out_valid, 1);
      check("hold_out_result", bus.out_result, 32'd2);
      check("hold_in_ready", bus.in_ready, 0);
    end
    present(2'b10, 6'h24, 32'hF0F0_F0F0, 32'hFF00_FF00);
    bus.out_ready = 1'b1;
    #1;
    check("same_cycle_accept", bus.in_ready, 1);
    finish_accept(2'b10, 6'h24, 32'hF0F0_F0F0, 32'hFF00_FF00);

    // Reset while the ALU result is in flight
    wait_drain();
    send_op(2'b10, 6'h20, 32'd3, 32'd4);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_in_ready", bus.in_ready, 0);
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_alu_control", alu_control, 0);
    check("midrst_alu_src1", alu_src1, 0);
    check("midrst_alu_src2", alu_src2, 0);
    check("midrst_out_result", bus.out_result, 0);
    check("midrst_op_count", op_count, 0);
    sb.delete();
    last_ctl = 4'b0000;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    directed("or_after_rst", 2'b10, 6'h25, 32'h1, 32'h2);

    // Randomized traffic with random back-pressure
    wait_drain();
    rand_ready_en = 1'b1;
    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 9))
        0:       op = 2'b11;
        1, 2:    op = 2'b00;
        3:       op = 2'b01;
        default: op = 2'b10;
      endcase
      f = ($urandom_range(0, 7) == 0) ? 6'($urandom) : legal_f[$urandom_range(0, 5)];
      a = ($urandom_range(0, 2) == 0) ? edge_v[$urandom_range(0, 4)] : $urandom;
      b = ($urandom_range(0, 2) == 0) ? edge_v[$urandom_range(0, 4)] : $urandom;
      if ($urandom_range(0, 3) == 0) b = a;
      repeat ($urandom_range(0, 2)) @(posedge clk);
      send_op(op, f, a, b);
    end
    rand_ready_en = 1'b0;
    wait_drain();
    check("final_op_count", op_count, exp_cnt);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
